aes_block_scanner: RTL and testbench

- Downstream consumer of the encrypt/decrypt cores' 128-bit result.
- Captures one 128-bit block through a valid/ready handshake.
- Presents the block one byte at a time to the seven-segment converter, together with its byte index, advancing on a programmable timebase.
- Lets the board show all 16 bytes of ciphertext or plaintext instead of a single fixed byte.

---
 rtl/aes_block_scanner.sv | 138 +++++++++++++
 tb/tb_aes_block_scanner.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_scanner.sv
// Captures one 128-bit AES result and scans it out a byte at a time for the 7-segment display.
// Optional compare-against-expected outputs are built when AES_SCAN_MATCH_EN is defined.
module aes_block_scanner #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter bit          LOOP     = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [127:0] in_data,
   output logic         in_ready,
   input  logic         pause,
   input  logic         step,
   output logic [7:0]   byte_out,
   output logic [3:0]   byte_idx,
   output logic         byte_valid,
   output logic         scan_done,
   output logic         busy
`ifdef AES_SCAN_MATCH_EN
   ,
   input  logic [127:0] expected,
   output logic         byte_match,
   output logic         block_match
`endif
);

   localparam int unsigned TW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {StIdle, StShow, StDone} state_e;

   state_e         state_q, state_d;
   logic [127:0]   block_q;
   logic [TW-1:0]  tick_q, tick_d;
   logic [7:0]     byte_d;
   logic [3:0]     idx_d;
   logic           done_d;
   logic           accept, tick_wrap, step_adv, advance, last;

   // Byte 0 is the most significant byte of the block.
   function automatic logic [7:0] pick(input logic [127:0] blk, input logic [3:0] idx);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 16; i++) begin
         if (idx == 4'(i)) r = blk[127-8*i -: 8];
      end
      return r;
   endfunction

   assign accept    = in_valid && in_ready;
   assign tick_wrap = (state_q == StShow) && !pause && (tick_q == TW'(TICK_DIV - 1));
   assign step_adv  = (state_q == StShow) && pause && step;
   // A reload on the same edge wins over any tick or step.
   assign advance   = !accept && (tick_wrap || step_adv);
   assign last      = (byte_idx == 4'd15);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept)                    state_d = StShow;
      else if (advance && last && !LOOP) state_d = StDone;
   end

   always_comb begin
      in_ready   = 1'b0;
      busy       = 1'b0;
      byte_valid = 1'b0;
      unique case (state_q)
         StIdle: in_ready = 1'b1;
         StShow: begin
            in_ready   = LOOP;
            busy       = 1'b1;
            byte_valid = 1'b1;
         end
         StDone: begin
            in_ready   = 1'b1;
            byte_valid = 1'b1;
         end
         default: in_ready = 1'b1;
      endcase
   end

   always_comb begin
      tick_d = tick_q;
      idx_d  = byte_idx;
      byte_d = byte_out;
      done_d = 1'b0;
      if (accept) begin
         tick_d = '0;
         idx_d  = 4'd0;
         byte_d = in_data[127:120];
      end else if (advance) begin
         tick_d = '0;
         done_d = last;
         if (!last) begin
            idx_d  = byte_idx + 4'd1;
            byte_d = pick(block_q, byte_idx + 4'd1);
         end else if (LOOP) begin
            idx_d  = 4'd0;
            byte_d = block_q[127:120];
         end
      end else if (state_q == StShow && !pause) begin
         tick_d = tick_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         block_q   <= '0;
         tick_q    <= '0;
         byte_out  <= 8'h00;
         byte_idx  <= 4'd0;
         scan_done <= 1'b0;
      end else begin
         if (accept) block_q <= in_data;
         tick_q    <= tick_d;
         byte_out  <= byte_d;
         byte_idx  <= idx_d;
         scan_done <= done_d;
      end
   end

`ifdef AES_SCAN_MATCH_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_match  <= 1'b0;
         block_match <= 1'b0;
      end else begin
         if (accept) block_match <= (in_data == expected);
         byte_match <= (state_d != StIdle) && (byte_d == pick(expected, idx_d));
      end
   end
`endif

endmodule

// File: tb/tb_aes_block_scanner.sv
// Scoreboard bench for aes_block_scanner: two instances (LOOP=1 and LOOP=0), TICK_DIV=4.
// Define AES_SCAN_MATCH_EN to also exercise byte_match/block_match.
module tb_aes_block_scanner;

   localparam logic [127:0] B1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   typedef struct {
      bit         which;
      logic       bv;
      logic [7:0] bo;
      logic [3:0] bi;
      logic       sd;
      logic       ir;
      logic       bz;
      bit         mchk;
      logic       bm;
      logic       blkm;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [127:0] in_data = '0;
   logic         pause = 1'b0;
   logic         step = 1'b0;
   logic [127:0] expv = '0;

   logic [7:0] l_bo, s_bo;
   logic [3:0] l_bi, s_bi;
   logic       l_ir, s_ir, l_bv, s_bv, l_sd, s_sd, l_bz, s_bz;
   logic       l_bm, s_bm, l_blkm, s_blkm;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   aes_block_scanner #(.TICK_DIV(4), .LOOP(1'b1)) u_loop (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(l_ir),
      .pause(pause), .step(step), .byte_out(l_bo), .byte_idx(l_bi), .byte_valid(l_bv),
      .scan_done(l_sd), .busy(l_bz)
`ifdef AES_SCAN_MATCH_EN
      , .expected(expv), .byte_match(l_bm), .block_match(l_blkm)
`endif
   );

   aes_block_scanner #(.TICK_DIV(4), .LOOP(1'b0)) u_stop (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(s_ir),
      .pause(pause), .step(step), .byte_out(s_bo), .byte_idx(s_bi), .byte_valid(s_bv),
      .scan_done(s_sd), .busy(s_bz)
`ifdef AES_SCAN_MATCH_EN
      , .expected(expv), .byte_match(s_bm), .block_match(s_blkm)
`endif
   );

`ifndef AES_SCAN_MATCH_EN
   assign l_bm = 1'b0;
   assign s_bm = 1'b0;
   assign l_blkm = 1'b0;
   assign s_blkm = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] bsel(input logic [127:0] b, input int i);
      return b[127-8*i -: 8];
   endfunction

   // Expected outputs c edges after the capturing edge, with no pause.
   function automatic exp_t show_exp(input bit which, input logic [127:0] blk, input int c,
                                     input bit loop);
      exp_t e;
      int   i;
      e.which = which; e.bv = 1'b1; e.mchk = 1'b0; e.bm = 1'b0; e.blkm = 1'b0;
      if (loop || c < 64) begin
         i    = (c / 4) % 16;
         e.bo = bsel(blk, i);
         e.bi = 4'(i);
         e.sd = (c > 0) && (c % 64 == 0);
         e.ir = loop;
         e.bz = 1'b1;
      end else begin
         e.bo = bsel(blk, 15);
         e.bi = 4'd15;
         e.sd = (c == 64);
         e.ir = 1'b1;
         e.bz = 1'b0;
      end
      return e;
   endfunction

   // from==0 presents blk on in_valid for the first cycle.
   task automatic run(input bit which, input logic [127:0] blk, input int from, input int to,
                      input bit loop, input bit m, input bit corrupt);
      exp_t e;
      for (int c = from; c <= to; c++) begin
         in_valid = (c == 0);
         in_data  = blk;
         e = show_exp(which, blk, c, loop);
         e.mchk = m;
         e.blkm = !corrupt;
         e.bm   = !(corrupt && e.bi == 4'd5);
         sb.push_back(e);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic hold(input logic [7:0] bo, input logic [3:0] bi);
      exp_t e;
      e.which = 1'b1; e.bv = 1'b1; e.bo = bo; e.bi = bi; e.sd = 1'b0; e.ir = 1'b1;
      e.bz = 1'b1; e.mchk = 1'b0; e.bm = 1'b0; e.blkm = 1'b0;
      sb.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: pops one expectation per cycle and compares just after the edge.
   initial begin
      exp_t e;
      logic [7:0] a_bo;
      logic [3:0] a_bi;
      logic a_bv, a_sd, a_ir, a_bz, a_bm, a_blkm;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.which) begin
               a_bo = l_bo; a_bi = l_bi; a_bv = l_bv; a_sd = l_sd; a_ir = l_ir; a_bz = l_bz;
               a_bm = l_bm; a_blkm = l_blkm;
            end else begin
               a_bo = s_bo; a_bi = s_bi; a_bv = s_bv; a_sd = s_sd; a_ir = s_ir; a_bz = s_bz;
               a_bm = s_bm; a_blkm = s_blkm;
            end
            chk("byte_out", 32'(a_bo), 32'(e.bo));
            chk("byte_idx", 32'(a_bi), 32'(e.bi));
            chk("byte_valid", 32'(a_bv), 32'(e.bv));
            chk("scan_done", 32'(a_sd), 32'(e.sd));
            chk("in_ready", 32'(a_ir), 32'(e.ir));
            chk("busy", 32'(a_bz), 32'(e.bz));
            if (e.mchk) begin
               chk("byte_match", 32'(a_bm), 32'(e.bm));
               chk("block_match", 32'(a_blkm), 32'(e.blkm));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_byte_out", 32'(l_bo), 32'h0);
      chk("rst_byte_idx", 32'(l_bi), 32'h0);
      chk("rst_byte_valid", 32'(l_bv), 32'h0);
      chk("rst_scan_done", 32'(l_sd), 32'h0);
      chk("rst_busy", 32'(l_bz), 32'h0);
      reset = 1'b0;
      #1;
      chk("rst_in_ready_loop", 32'(l_ir), 32'h1);
      chk("rst_in_ready_stop", 32'(s_ir), 32'h1);

      // Full loop scan, wraps back to byte 0 with a scan_done pulse.
      run(1'b1, B1, 0, 67, 1'b1, 1'b0, 1'b0);

      // Reload, then pause at idx 3, step three times, step ignored when unpaused.
      run(1'b1, B1, 0, 12, 1'b1, 1'b0, 1'b0);
      pause = 1'b1;
      repeat (20) hold(8'h33, 4'd3);
      step = 1'b1; hold(8'h44, 4'd4);
      step = 1'b0; hold(8'h44, 4'd4);
      step = 1'b1; hold(8'h55, 4'd5);
      step = 1'b0; hold(8'h55, 4'd5);
      step = 1'b1; hold(8'h66, 4'd6);
      step = 1'b0; hold(8'h66, 4'd6);
      pause = 1'b0;
      step = 1'b1; hold(8'h66, 4'd6);
      step = 1'b0; hold(8'h66, 4'd6);
      hold(8'h66, 4'd6);
      hold(8'h77, 4'd7);
      for (int k = 1; k <= 11; k++) hold(bsel(B1, 7 + k / 4), 4'(7 + k / 4));

      // Reload on the idx 9 -> 10 wrap edge.
      run(1'b1, B2, 0, 28, 1'b1, 1'b0, 1'b0);

      // Reset at idx 7 aborts the scan.
      reset = 1'b1;
      #1;
      chk("abort_byte_out", 32'(l_bo), 32'h0);
      chk("abort_byte_idx", 32'(l_bi), 32'h0);
      chk("abort_byte_valid", 32'(l_bv), 32'h0);
      chk("abort_scan_done", 32'(l_sd), 32'h0);
      chk("abort_busy", 32'(l_bz), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("abort_in_ready", 32'(l_ir), 32'h1);
      run(1'b1, B1, 0, 5, 1'b1, 1'b0, 1'b0);

      // LOOP=0: stop on byte 15 in DONE, then accept a new block.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      run(1'b0, B1, 0, 67, 1'b0, 1'b0, 1'b0);
      run(1'b0, B2, 0, 4, 1'b0, 1'b0, 1'b0);

`ifdef AES_SCAN_MATCH_EN
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expv = B1;
      run(1'b1, B1, 0, 63, 1'b1, 1'b1, 1'b0);
      expv = B1 & ~(128'hff << 80);
      run(1'b1, B1, 0, 27, 1'b1, 1'b1, 1'b1);
`endif

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
